bus_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave bus arbiter for the lab bus protocol: `pkg_trans` transfer types and `pkg_resp` response codes. It replaces point-to-point master/slave wiring. It selects one pending master request by round-robin, forwards it to the slave, and waits for a non-PENDING response. It returns that response to the granted master, and aborts a stuck transfer with ERROR_2 after a configurable timeout.

---
 rtl/bus_rr_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// bus_rr_arbiter
// N-master to 1-slave arbiter for the lab bus. Pending master requests are
// granted round-robin, the granted request is forwarded to the slave through
// registers, and the slave's first non-PENDING response is returned to the
// granted master for exactly one cycle. A transfer that stays PENDING for
// TIMEOUT BUSY cycles is aborted with ERROR_2 (TIMEOUT = 0 disables this).
// Every output is a register; nothing combinational reaches the ports.
// ----------------------------------------------------------------------------

package pkg_trans;
    // One bit per master on m_trans, so the transfer type is a single bit.
    typedef enum logic {
        IDLE   = 1'b0,
        NONSEQ = 1'b1
    } trans_t;
endpackage

package pkg_resp;
    typedef enum logic [1:0] {
        PENDING = 2'b00,
        SUCCESS = 2'b01,
        ERROR_1 = 2'b10,
        ERROR_2 = 2'b11
    } resp_t;
endpackage

module bus_rr_arbiter #(
    parameter int NUM_MASTER = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int ID_W       = $clog2(NUM_MASTER)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_MASTER-1:0]        m_trans,
    input  logic [NUM_MASTER-1:0]        m_write,
    input  logic [NUM_MASTER*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTER*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTER*2-1:0]      m_resp,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_trans,
    output logic                         s_write,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [1:0]                   s_resp,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
);

    // Counter only has to reach TIMEOUT-1; keep at least one bit so the
    // design still elaborates with the timeout disabled.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_MASTER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [ID_W-1:0]          ptr_r;
    logic [ID_W-1:0]          ptr_nxt_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_nxt_s;

    logic [ID_W-1:0]          grant_nxt_s;
    logic                     s_trans_nxt_s;
    logic                     s_write_nxt_s;
    logic [ADDR_W-1:0]        s_addr_nxt_s;
    logic [DATA_W-1:0]        s_wdata_nxt_s;
    logic [NUM_MASTER*2-1:0]  m_resp_nxt_s;
    logic [DATA_W-1:0]        m_rdata_nxt_s;
    logic                     busy_nxt_s;

    logic                     cap_valid_s;
    logic [1:0]               cap_code_s;
    logic [DATA_W-1:0]        cap_data_s;

    logic                     req_found_s;
    logic [ID_W-1:0]          req_idx_s;
    logic [ID_W-1:0]          scan_idx_s;

    logic [ADDR_W-1:0]        addr_a_s  [NUM_MASTER];
    logic [DATA_W-1:0]        wdata_a_s [NUM_MASTER];

    // Unpack the flat master address/data buses into per-master arrays.
    always_comb begin
        for (int i = 0; i < NUM_MASTER; i++) begin
            addr_a_s[i]  = m_addr[i*ADDR_W +: ADDR_W];
            wdata_a_s[i] = m_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: first NONSEQ requester scanning upward from ptr_r.
    always_comb begin
        req_found_s = 1'b0;
        req_idx_s   = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NUM_MASTER; k++) begin
            scan_idx_s = ID_W'((int'(ptr_r) + k) % NUM_MASTER);
            if (!req_found_s && (m_trans[scan_idx_s] == pkg_trans::NONSEQ)) begin
                req_found_s = 1'b1;
                req_idx_s   = scan_idx_s;
            end else begin
                req_found_s = req_found_s;
            end
        end
    end

    // Next-state and next-output logic of the IDLE/BUSY/RESP transfer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        grant_nxt_s   = grant_id;
        s_trans_nxt_s = s_trans;
        s_write_nxt_s = s_write;
        s_addr_nxt_s  = s_addr;
        s_wdata_nxt_s = s_wdata;
        m_resp_nxt_s  = '0;
        m_rdata_nxt_s = m_rdata;
        cap_valid_s   = 1'b0;
        cap_code_s    = pkg_resp::PENDING;
        cap_data_s    = '0;

        case (state_r)
            ST_IDLE: begin
                if (req_found_s) begin
                    s_trans_nxt_s = pkg_trans::NONSEQ;
                    s_write_nxt_s = m_write[req_idx_s];
                    s_addr_nxt_s  = addr_a_s[req_idx_s];
                    s_wdata_nxt_s = wdata_a_s[req_idx_s];
                    grant_nxt_s   = req_idx_s;
                    ptr_nxt_s     = (req_idx_s == LAST_ID) ? '0 : req_idx_s + ID_W'(1);
                    cnt_nxt_s     = '0;
                    state_nxt_s   = ST_BUSY;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end

            ST_BUSY: begin
                // The slave response is checked first so it wins over a
                // timeout landing in the same cycle.
                if (s_resp != pkg_resp::PENDING) begin
                    cap_valid_s   = 1'b1;
                    cap_code_s    = s_resp;
                    cap_data_s    = s_rdata;
                    s_trans_nxt_s = pkg_trans::IDLE;
                    state_nxt_s   = ST_RESP;
                end else if ((TIMEOUT > 0) && (cnt_r == TMO_LAST)) begin
                    cap_valid_s   = 1'b1;
                    cap_code_s    = pkg_resp::ERROR_2;
                    cap_data_s    = '0;
                    s_trans_nxt_s = pkg_trans::IDLE;
                    state_nxt_s   = ST_RESP;
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s   = ST_IDLE;
                s_trans_nxt_s = pkg_trans::IDLE;
            end
        endcase

        // Only the granted master sees the captured code; all others PENDING.
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (cap_valid_s && (ID_W'(i) == grant_id)) begin
                m_resp_nxt_s[2*i +: 2] = cap_code_s;
            end else begin
                m_resp_nxt_s[2*i +: 2] = pkg_resp::PENDING;
            end
        end

        if (cap_valid_s) begin
            m_rdata_nxt_s = cap_data_s;
        end else begin
            m_rdata_nxt_s = m_rdata;
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, pointer, counter and every output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            cnt_r    <= '0;
            grant_id <= '0;
            s_trans  <= pkg_trans::IDLE;
            s_write  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m_resp   <= '0;
            m_rdata  <= '0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            grant_id <= grant_nxt_s;
            s_trans  <= s_trans_nxt_s;
            s_write  <= s_write_nxt_s;
            s_addr   <= s_addr_nxt_s;
            s_wdata  <= s_wdata_nxt_s;
            m_resp   <= m_resp_nxt_s;
            m_rdata  <= m_rdata_nxt_s;
            busy     <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_rr_arbiter
// Directed scenarios followed by a randomized phase. The bench plays all
// masters and the slave; expected grants come from a round-robin pick over
// the set of pending masters, expected responses from the slave latency
// versus the timeout.
// ----------------------------------------------------------------------------

module tb_bus_rr_arbiter;
    import pkg_resp::*;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int IW  = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_trans;
    logic [N-1:0]    m_write;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*2-1:0]  m_resp;
    logic [DW-1:0]   m_rdata;
    logic            s_trans;
    logic            s_write;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [1:0]      s_resp;
    logic [DW-1:0]   s_rdata;
    logic [IW-1:0]   grant_id;
    logic            busy;

    bus_rr_arbiter #(
        .NUM_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_trans(m_trans), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_resp(m_resp), .m_rdata(m_rdata),
        .s_trans(s_trans), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_resp(s_resp), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending set, per-master request fields, rr pointer.
    int          exp_ptr = 0;
    bit          pend   [N];
    logic        wr_q   [N];
    logic [31:0] addr_q [N];
    logic [31:0] wd_q   [N];
    int          g;
    logic [1:0]  rcode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] resp_vec(input int who, input logic [1:0] code);
        logic [2*N-1:0] v;
        for (int i = 0; i < N; i++) v[2*i +: 2] = (i == who) ? code : PENDING;
        return v;
    endfunction

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic request(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        pend[i] = 1'b1; wr_q[i] = w; addr_q[i] = a; wd_q[i] = d;
        m_trans[i] = 1'b1;
        m_write[i] = w;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic release_m(input int i);
        pend[i] = 1'b0;
        m_trans[i] = 1'b0;
        m_write[i] = 1'($urandom);
        m_addr[i*AW +: AW] = $urandom;
    endtask

    // Called at the negedge of an IDLE cycle with at least one master pending.
    // Returns at the negedge of the RESP cycle after releasing the grantee.
    task automatic do_transfer(input int lat, input logic [1:0] code,
                               input logic [31:0] rd, output int who);
        int          eff;
        logic [1:0]  exp_code;
        logic [31:0] exp_rd;
        who      = rr_pick();
        exp_ptr  = (who + 1) % N;
        eff      = (lat <= TMO) ? lat : TMO;
        exp_code = (lat <= TMO) ? code : ERROR_2;
        exp_rd   = (lat <= TMO) ? rd : 32'h0;
        @(negedge clk);
        for (int j = 1; j <= eff; j++) begin
            check("busy_s_trans",  s_trans,  1);
            check("busy_flag",     busy,     1);
            check("busy_grant_id", grant_id, who);
            check("busy_s_addr",   s_addr,   addr_q[who]);
            check("busy_s_write",  s_write,  wr_q[who]);
            check("busy_s_wdata",  s_wdata,  wd_q[who]);
            check("busy_m_resp",   m_resp,   resp_vec(-1, PENDING));
            if (j == lat) begin
                s_resp = code;    s_rdata = rd;
            end else begin
                s_resp = PENDING; s_rdata = $urandom;
            end
            @(negedge clk);
        end
        // Noise on the slave response outside BUSY must be ignored.
        s_resp  = ERROR_1;
        s_rdata = $urandom;
        check("resp_m_resp",   m_resp,   resp_vec(who, exp_code));
        check("resp_m_rdata",  m_rdata,  exp_rd);
        check("resp_s_trans",  s_trans,  0);
        check("resp_busy",     busy,     1);
        check("resp_grant_id", grant_id, who);
        release_m(who);
    endtask

    task automatic to_idle();
        @(negedge clk);
        check("idle_busy",    busy,    0);
        check("idle_s_trans", s_trans, 0);
        check("idle_m_resp",  m_resp,  resp_vec(-1, PENDING));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_trans = '0; m_write = '0; m_addr = '0; m_wdata = '0;
        s_resp = PENDING; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; wr_q[i] = 1'b0; addr_q[i] = '0; wd_q[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_s_trans",  s_trans,  0);
        check("rst_busy",     busy,     0);
        check("rst_grant_id", grant_id, 0);
        check("rst_s_write",  s_write,  0);
        check("rst_s_addr",   s_addr,   0);
        check("rst_s_wdata",  s_wdata,  0);
        check("rst_m_resp",   m_resp,   resp_vec(-1, PENDING));
        check("rst_m_rdata",  m_rdata,  0);
        rst = 1'b0;
        repeat (2) to_idle();

        // Round-robin: 0,1,3 request together, 0 re-requests after its turn.
        request(0, 1'b0, 32'h1000, 32'h0);
        request(1, 1'b1, 32'h1100, 32'h11);
        request(3, 1'b0, 32'h1300, 32'h0);
        do_transfer(1, SUCCESS, 32'h0000_00A0, g);
        request(0, 1'b1, 32'h2000, 32'h22);
        to_idle();
        do_transfer(1, SUCCESS, 32'h0000_00A1, g); to_idle();
        do_transfer(1, SUCCESS, 32'h0000_00A3, g); to_idle();
        do_transfer(1, SUCCESS, 32'h0000_00A4, g); to_idle();

        // Single read from master 2, two BUSY cycles.
        request(2, 1'b0, 32'h100, 32'h0);
        do_transfer(2, SUCCESS, 32'hDEADBEEF, g); to_idle();

        // Write from master 1 answered with ERROR_2 by the slave.
        request(1, 1'b1, 32'h20, 32'hA5A5);
        do_transfer(1, ERROR_2, 32'h1234_5678, g); to_idle();

        // Timeout: slave never answers.
        request(3, 1'b0, 32'h40, 32'h0);
        do_transfer(100, SUCCESS, 32'hFFFF_FFFF, g); to_idle();

        // Collision: ERROR_1 exactly in the last BUSY cycle before timeout.
        request(0, 1'b0, 32'h44, 32'h0);
        do_transfer(TMO, ERROR_1, 32'hCAFE_F00D, g); to_idle();

        // Reset in the middle of a transfer from master 2.
        s_resp = PENDING;
        request(2, 1'b1, 32'h300, 32'h55);
        @(negedge clk);
        check("pre_rst_s_trans", s_trans, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_s_trans",  s_trans,  0);
        check("midrst_busy",     busy,     0);
        check("midrst_m_resp",   m_resp,   resp_vec(-1, PENDING));
        check("midrst_grant_id", grant_id, 0);
        check("midrst_s_addr",   s_addr,   0);
        release_m(2);
        @(negedge clk);
        check("inrst_busy", busy, 0);
        rst = 1'b0;
        exp_ptr = 0;
        request(3, 1'b0, 32'h330, 32'h0);
        request(0, 1'b0, 32'h300, 32'h0);
        do_transfer(1, SUCCESS, 32'h0BAD_0001, g); to_idle();
        do_transfer(1, SUCCESS, 32'h0BAD_0003, g); to_idle();

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (!any_pend()) begin
                repeat ($urandom_range(0, 2)) to_idle();
                request($urandom_range(0, N - 1), 1'($urandom), $urandom, $urandom);
            end
            rcode = 2'($urandom_range(1, 3));
            do_transfer($urandom_range(1, 6), rcode, $urandom, g);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0))
                    request(i, 1'($urandom), $urandom, $urandom);
            end
            to_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
